sub_pipe_arbiter: RTL and testbench
===================================

# sub_pipe_arbiter

Round-robin arbiter that shares one modular subtractor pipeline (two-operand stream in, one result stream out, fixed latency, in-order, no sideband tag) among NUM_REQ requesters. Each accepted request pushes its requester ID into an in-order tag FIFO. Each pipeline result is routed back to the requester at the FIFO head. The block sits between the per-lane field-arithmetic schedulers and the single shared subtractor instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- C_DATA_WIDTH, 32, operand and result width
- TAG_DEPTH, 8, tag FIFO depth; power of 2; must be ≥ pipeline LEVEL+1 for full throughput
- ID_BITS, $clog2(NUM_REQ), requester ID width
- CNT_BITS, $clog2(TAG_DEPTH)+1, outstanding-count width

Ports:
- aclk  in  1  clock; all state updates on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_req_tvalid  in  [NUM_REQ]  request valid per requester
- s_req_tdata  in  [NUM_REQ][2][C_DATA_WIDTH]  operands; [0]=minuend a, [1]=subtrahend b
- s_req_tready  out  [NUM_REQ]  request accepted this cycle
- m_rsp_tvalid  out  [NUM_REQ]  result valid; at most one bit high
- m_rsp_tdata  out  C_DATA_WIDTH  result; shared by all requesters
- m_rsp_tready  in  [NUM_REQ]  requester accepts result
- p_tvalid  out  [2]  pipeline operand valid; both bits always equal
- p_tdata  out  [2][C_DATA_WIDTH]  pipeline operands
- p_tready  in  [2]  pipeline ready; only bit 0 is used
- p_res_tvalid  in  1  pipeline result valid
- p_res_tdata  in  C_DATA_WIDTH  pipeline result
- p_res_tready  out  1  backpressure to the pipeline
- outstanding  out  CNT_BITS  registered tag FIFO occupancy
- err_orphan  out  1  sticky; a result arrived while the tag FIFO was empty

## Operation
- Priority pointer ptr (ID_BITS, registered).
  - Grant goes to the first i with s_req_tvalid[i]=1, searching ptr, ptr+1, … mod NUM_REQ.
- issue = any valid && !fifo_full && p_tready[0].
  - p_tvalid[0] = p_tvalid[1] = any valid && !fifo_full.
  - p_tdata = s_req_tdata[grant]. When no request is valid, p_tdata = 0.
  - s_req_tready[grant] = issue. All other s_req_tready bits are 0.
- On issue:
  - push grant ID into the tag FIFO;
  - ptr ← (grant+1) mod NUM_REQ.
  - Without issue, ptr holds.
- Response routing when fifo_empty=0:
  - m_rsp_tvalid[head] = p_res_tvalid; all other bits 0;
  - m_rsp_tdata = p_res_tdata;
  - p_res_tready = m_rsp_tready[head].
- Pop when p_res_tvalid && p_res_tready && !fifo_empty.
- Orphan result (p_res_tvalid=1 while fifo_empty=1):
  - p_res_tready=1 and the result is dropped;
  - all m_rsp_tvalid bits stay 0;
  - err_orphan ← 1. It clears only on reset.
- Simultaneous push and pop:
  - allowed when the FIFO is neither full nor empty; outstanding is unchanged.
  - When full, push is blocked even if a pop occurs the same cycle. This keeps the response path out of the request-ready path.
  - When empty, a result cannot pop; it is handled as an orphan.
- FIFO pointers are ID_BITS-wide entries, log2(TAG_DEPTH)+1-bit read/write pointers with a wrap bit.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - outstanding = wr_ptr − rd_ptr, modulo 2^CNT_BITS.
- Reset (aresetn=0, takes effect asynchronously):
  - ptr=0, FIFO empty, outstanding=0, err_orphan=0;
  - all s_req_tready, m_rsp_tvalid, p_tvalid and p_res_tready forced to 0.
  - Reset mid-operation discards all in-flight tags. The pipeline must be reset in the same cycle.

## Timing
- Issue path is combinational: request valid → p_tvalid and s_req_tready in the same cycle. Accept on the cycle where s_req_tvalid and s_req_tready are both high.
- Response path is combinational: p_res_tvalid → m_rsp_tvalid, and m_rsp_tready → p_res_tready.
- Added latency is 0 cycles on both paths. End-to-end latency equals the pipeline latency.
- Throughput: 1 issue/cycle while outstanding < TAG_DEPTH.
- outstanding, ptr and err_orphan update one cycle after the triggering edge.
- A requester holding s_req_tvalid with stable data is granted within NUM_REQ issue cycles (fairness bound).
- Per-requester result order equals issue order.

## Test plan
- Reset, then requester 2 alone sends a=10, b=3 → s_req_tready[2]=1 in the same cycle; the pipe result is routed only to m_rsp_tvalid[2]; outstanding goes 0→1→0.
- All 4 requesters valid continuously, all m_rsp_tready=1 → grant order 0,1,2,3,0,…; each requester gets its results in issue order.
- TAG_DEPTH=8, pipeline p_res_tready withheld (m_rsp_tready=0) → exactly 8 issues, then p_tvalid=0 and outstanding=8; releasing one response allows issue again the following cycle.
- p_tready[0]=0 with requests valid → no s_req_tready, ptr holds, no push.
- Inject p_res_tvalid=1 with an empty FIFO → p_res_tready=1, no m_rsp_tvalid, err_orphan=1 until aresetn.
- Assert aresetn=0 with outstanding=5 mid-stream → all outputs 0 immediately; after release outstanding=0, ptr=0, first grant goes to the lowest valid ID.

Source files
------------

// File: rtl/sub_pipe_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one in-order, fixed-latency
// subtractor pipeline. Requester IDs are queued in issue order so results can be routed back
// without a sideband tag on the pipeline itself.
module sub_pipe_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned ID_BITS      = $clog2(NUM_REQ),
  parameter int unsigned CNT_BITS     = $clog2(TAG_DEPTH) + 1
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [NUM_REQ-1:0]                       s_req_tvalid,
  input  logic [NUM_REQ-1:0][1:0][C_DATA_WIDTH-1:0] s_req_tdata,
  output logic [NUM_REQ-1:0]                       s_req_tready,
  output logic [NUM_REQ-1:0]                       m_rsp_tvalid,
  output logic [C_DATA_WIDTH-1:0]                  m_rsp_tdata,
  input  logic [NUM_REQ-1:0]                       m_rsp_tready,
  output logic [1:0]                               p_tvalid,
  output logic [1:0][C_DATA_WIDTH-1:0]             p_tdata,
  input  logic [1:0]                               p_tready,
  input  logic                                     p_res_tvalid,
  input  logic [C_DATA_WIDTH-1:0]                  p_res_tdata,
  output logic                                     p_res_tready,
  output logic [CNT_BITS-1:0]                      outstanding,
  output logic                                     err_orphan
);

  localparam int unsigned AW = $clog2(TAG_DEPTH);

  logic [ID_BITS-1:0]  ptr_q, ptr_d;
  logic [ID_BITS-1:0]  grant;
  logic                any_valid;
  logic                fifo_full, fifo_empty;
  logic                issue, pop;
  logic [CNT_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ID_BITS-1:0]  tag_mem_q [TAG_DEPTH];
  logic [ID_BITS-1:0]  head;
  logic                err_orphan_q, err_orphan_d;
  logic                unused_ready;

  // Only lane 0 of the pipeline ready is meaningful; both lanes move together.
  assign unused_ready = p_tready[1];

  assign any_valid  = |s_req_tvalid;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[CNT_BITS-1] != rd_ptr_q[CNT_BITS-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = tag_mem_q[rd_ptr_q[AW-1:0]];

  // Full blocks issue even if a pop lands in the same cycle, keeping response timing
  // out of the request-ready path.
  assign issue = aresetn & any_valid & ~fifo_full & p_tready[0];
  assign pop   = aresetn & p_res_tvalid & ~fifo_empty & m_rsp_tready[head];

  assign outstanding = wr_ptr_q - rd_ptr_q;
  assign err_orphan  = err_orphan_q;
  assign m_rsp_tdata = p_res_tdata;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && s_req_tvalid[idx[ID_BITS-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_BITS-1:0];
      end
    end
  end

  // Request side: grant steering and pipeline operand drive.
  always_comb begin
    s_req_tready = '0;
    if (issue) s_req_tready[grant] = 1'b1;
    p_tvalid = {2{aresetn & any_valid & ~fifo_full}};
    p_tdata  = any_valid ? s_req_tdata[grant] : '0;
  end

  // Response side: route to the requester at the tag FIFO head; orphans are swallowed.
  always_comb begin
    m_rsp_tvalid = '0;
    p_res_tready = 1'b0;
    if (aresetn) begin
      if (fifo_empty) begin
        p_res_tready = 1'b1;
      end else begin
        m_rsp_tvalid[head] = p_res_tvalid;
        p_res_tready       = m_rsp_tready[head];
      end
    end
  end

  // Next-state for pointer, FIFO pointers and sticky orphan flag.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      if (32'(grant) == NUM_REQ - 1) ptr_d = '0;
      else                           ptr_d = grant + 1'b1;
    end
    wr_ptr_d     = issue ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_orphan_d = err_orphan_q | (p_res_tvalid & fifo_empty);
  end

  // Control state; reset drops every in-flight tag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage; contents are don't-care while the FIFO is empty, so no reset.
  always_ff @(posedge aclk) begin
    if (issue) tag_mem_q[wr_ptr_q[AW-1:0]] <= grant;
  end

endmodule

// File: tb/tb_sub_pipe_arbiter.sv
// Self-checking bench for sub_pipe_arbiter with an elastic fixed-latency subtractor model.
module tb_sub_pipe_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int CB  = 4;
  localparam int LAT = 3;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [N-1:0]            s_req_tvalid = '0;
  logic [N-1:0][1:0][W-1:0] s_req_tdata;
  logic [N-1:0]            s_req_tready;
  logic [N-1:0]            m_rsp_tvalid;
  logic [W-1:0]            m_rsp_tdata;
  logic [N-1:0]            m_rsp_tready = '0;
  logic [1:0]              p_tvalid;
  logic [1:0][W-1:0]       p_tdata;
  logic [1:0]              p_tready;
  logic                    p_res_tvalid = 1'b0;
  logic [W-1:0]            p_res_tdata = '0;
  logic                    p_res_tready;
  logic [CB-1:0]           outstanding;
  logic                    err_orphan;

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic         pt_ready = 1'b1;

  assign p_tready = {~pt_ready, pt_ready};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_req_tdata[i][0] = a_v[i];
      s_req_tdata[i][1] = b_v[i];
    end
  end

  always #5 aclk = ~aclk;

  sub_pipe_arbiter #(
    .NUM_REQ(N), .C_DATA_WIDTH(W), .TAG_DEPTH(D)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_tvalid(s_req_tvalid), .s_req_tdata(s_req_tdata), .s_req_tready(s_req_tready),
    .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tdata(m_rsp_tdata), .m_rsp_tready(m_rsp_tready),
    .p_tvalid(p_tvalid), .p_tdata(p_tdata), .p_tready(p_tready),
    .p_res_tvalid(p_res_tvalid), .p_res_tdata(p_res_tdata), .p_res_tready(p_res_tready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per accepted request, in issue order.
  typedef struct { int id; logic [W-1:0] d; } sb_t;
  sb_t sbq[$];
  int  model_ptr = 0;
  bit  model_err = 0;
  int  dut_grants[$];
  int  dut_issue_cnt = 0;
  logic [N-1:0] acc_mask = '0;

  // Handshakes seen at negedge, consumed by the pipeline model at the next posedge.
  bit           pend_push = 0;
  bit           pend_pop = 0;
  logic [W-1:0] pend_d = '0;

  // Pipeline model state.
  typedef struct { logic [W-1:0] d; int t; } pe_t;
  pe_t          pq[$];
  int           cyc = 0;
  bit           pres_orph = 0;
  int           inj_req = 0;
  int           inj_done = 0;
  logic [W-1:0] inj_d = 32'hDEAD_BEEF;

  // Elastic pipeline: result available LAT-1 cycles after acceptance, held until taken.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pq.delete();
      p_res_tvalid = 1'b0;
      p_res_tdata  = '0;
      pres_orph    = 0;
      inj_done     = inj_req;
    end else begin
      #1;
      cyc++;
      if (pend_pop) begin
        if (pres_orph) inj_done = inj_req;
        else if (pq.size() > 0) void'(pq.pop_front());
      end
      if (pend_push) pq.push_back('{pend_d, cyc + LAT - 1});
      if (pq.size() > 0 && pq[0].t <= cyc) begin
        p_res_tvalid = 1'b1;
        p_res_tdata  = pq[0].d;
        pres_orph    = 0;
      end else if (pq.size() == 0 && inj_req != inj_done) begin
        p_res_tvalid = 1'b1;
        p_res_tdata  = inj_d;
        pres_orph    = 1;
      end else begin
        p_res_tvalid = 1'b0;
        p_res_tdata  = '0;
        pres_orph    = 0;
      end
    end
  end

  // Per-cycle reference check of every output against the bench model.
  task automatic mon();
    bit any, full, empty, found, exp_issue;
    int g, hid;
    logic [N-1:0] exp_rdy, exp_mv;
    logic exp_prr;
    if (!aresetn) begin
      chk("rst_s_req_tready", s_req_tready, 0);
      chk("rst_m_rsp_tvalid", m_rsp_tvalid, 0);
      chk("rst_p_tvalid", p_tvalid, 0);
      chk("rst_p_res_tready", p_res_tready, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_orphan", err_orphan, 0);
      sbq.delete();
      model_ptr = 0;
      model_err = 0;
      pend_push = 0;
      pend_pop  = 0;
      acc_mask  = '0;
      return;
    end
    any = |s_req_tvalid;
    full = sbq.size() >= D;
    g = 0;
    found = 0;
    hid = 0;
    for (int k = 0; k < N; k++) begin
      int j = (model_ptr + k) % N;
      if (!found && s_req_tvalid[j]) begin
        found = 1;
        g = j;
      end
    end
    exp_issue = any && !full && p_tready[0];
    exp_rdy = exp_issue ? (N'(1) << g) : '0;
    chk("s_req_tready", s_req_tready, exp_rdy);
    chk("p_tvalid", p_tvalid, (any && !full) ? 2'b11 : 2'b00);
    if (!any) chk("p_tdata_idle", p_tdata, 0);
    chk("outstanding", outstanding, sbq.size());
    chk("err_orphan", err_orphan, model_err);
    empty = sbq.size() == 0;
    if (empty) begin
      exp_mv  = '0;
      exp_prr = 1'b1;
    end else begin
      hid     = sbq[0].id;
      exp_mv  = p_res_tvalid ? (N'(1) << hid) : '0;
      exp_prr = m_rsp_tready[hid];
    end
    chk("m_rsp_tvalid", m_rsp_tvalid, exp_mv);
    chk("p_res_tready", p_res_tready, exp_prr);
    if (p_res_tvalid && !empty && m_rsp_tready[hid]) begin
      chk("rsp_data", m_rsp_tdata, sbq[0].d);
      void'(sbq.pop_front());
    end
    if (p_res_tvalid && empty) model_err = 1;
    if (exp_issue) begin
      sbq.push_back('{g, a_v[g] - b_v[g]});
      model_ptr = (g + 1) % N;
    end
    if (s_req_tready != '0) begin
      dut_issue_cnt++;
      for (int k = 0; k < N; k++) if (s_req_tready[k]) dut_grants.push_back(k);
    end
    pend_push = p_tvalid[0] && p_tready[0];
    pend_d    = p_tdata[0] - p_tdata[1];
    pend_pop  = p_res_tvalid && p_res_tready;
    acc_mask  = s_req_tvalid & s_req_tready;
  endtask

  // Advance one cycle: check at negedge, return at posedge+1 for driving.
  task automatic tick();
    @(negedge aclk);
    mon();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
  endtask

  task automatic drain();
    int k;
    s_req_tvalid = '0;
    m_rsp_tready = '1;
    for (k = 0; k < 100; k++) begin
      tick();
      if (outstanding == 0 && pq.size() == 0) break;
    end
    chk("drain_done", k < 100, 1);
  endtask

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;
  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base, start_ptr;
    bit found;
    vecs[0] = '{2, 32'd10, 32'd3, 32'd7};
    vecs[1] = '{0, 32'd1, 32'd2, 32'hFFFF_FFFF};
    vecs[2] = '{3, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
    vecs[3] = '{1, 32'd5, 32'd5, 32'd0};
    vecs[4] = '{2, 32'd0, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    @(posedge aclk);
    #1;
    do_reset();

    // Single-requester vectors: same-cycle ready, result routed only to that requester.
    for (int v = 0; v < 5; v++) begin
      m_rsp_tready = '1;
      a_v[vecs[v].id] = vecs[v].a;
      b_v[vecs[v].id] = vecs[v].b;
      s_req_tvalid = N'(1) << vecs[v].id;
      #1;
      chk("vec_ready", s_req_tready, N'(1) << vecs[v].id);
      tick();
      s_req_tvalid = '0;
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
        #1;
        if (m_rsp_tvalid != '0) begin
          found = 1;
          chk("vec_rsp_onehot", m_rsp_tvalid, N'(1) << vecs[v].id);
          chk("vec_result", m_rsp_tdata, vecs[v].exp);
        end
        tick();
      end
      chk("vec_rsp_seen", found, 1);
    end
    drain();

    // Continuous contention: grant order 0,1,2,3,... from a fresh pointer.
    do_reset();
    base = dut_grants.size();
    m_rsp_tready = '1;
    for (int i = 0; i < N; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    s_req_tvalid = '1;
    repeat (24) begin
      tick();
      for (int i = 0; i < N; i++) if (acc_mask[i]) begin
        a_v[i] = $urandom;
        b_v[i] = $urandom;
      end
    end
    chk("rr_count", dut_grants.size() - base >= 8, 1);
    for (int i = 0; i < 8; i++)
      if (base + i < dut_grants.size()) chk("rr_order", dut_grants[base + i], i % N);
    drain();

    // Tag FIFO full: exactly D issues, then one released response reopens issue.
    do_reset();
    base = dut_issue_cnt;
    m_rsp_tready = '0;
    s_req_tvalid = '1;
    repeat (16) tick();
    chk("full_issues", dut_issue_cnt - base, D);
    #1;
    chk("full_outstanding", outstanding, D);
    chk("full_p_tvalid", p_tvalid, 0);
    tick();
    m_rsp_tready = '1;
    tick();
    m_rsp_tready = '0;
    #1;
    chk("refill_issue", |s_req_tready, 1);
    tick();
    drain();

    // Pipeline not ready: nothing accepted and pointer holds.
    start_ptr = model_ptr;
    pt_ready = 1'b0;
    s_req_tvalid = '1;
    repeat (4) begin
      #1;
      chk("stall_ready", s_req_tready, 0);
      tick();
    end
    pt_ready = 1'b1;
    #1;
    chk("stall_resume", s_req_tready, N'(1) << start_ptr);
    tick();
    drain();

    // Orphan result: swallowed, no response, sticky error until reset.
    inj_req++;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (p_res_tvalid) begin
        found = 1;
        chk("orphan_ready", p_res_tready, 1);
        chk("orphan_no_rsp", m_rsp_tvalid, 0);
      end
      tick();
    end
    chk("orphan_seen", found, 1);
    repeat (3) tick();
    #1;
    chk("orphan_sticky", err_orphan, 1);
    do_reset();
    #1;
    chk("orphan_cleared", err_orphan, 0);

    // Reset mid-stream with five tags in flight.
    m_rsp_tready = '0;
    s_req_tvalid = '1;
    repeat (5) tick();
    s_req_tvalid = '0;
    #1;
    chk("mid_outstanding", outstanding, 5);
    #1;
    aresetn = 1'b0;
    s_req_tvalid = '1;
    m_rsp_tready = '1;
    #1;
    chk("async_s_req_tready", s_req_tready, 0);
    chk("async_m_rsp_tvalid", m_rsp_tvalid, 0);
    chk("async_p_tvalid", p_tvalid, 0);
    chk("async_p_res_tready", p_res_tready, 0);
    chk("async_outstanding", outstanding, 0);
    repeat (2) tick();
    aresetn = 1'b1;
    s_req_tvalid = 4'b1001;
    #1;
    chk("post_rst_grant", s_req_tready, 4'b0001);
    chk("post_rst_outstanding", outstanding, 0);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
